// File: rtl/screen_fader.sv
// screen_fader: scales the final VGA colour stream by a per-frame brightness
// level (0..16) and steps that level on fade-out / fade-in requests.
// Colour and both syncs share the same 2-cycle pipeline so they stay aligned.
// Optional build macro FADE_TINT_EN: fade towards TINT_RGB instead of black.
//
// state      | meaning
// BRIGHT     | idle at full brightness, level 16
// FADING_OUT | level steps down every FRAMES_PER_STEP frame ticks
// DARK       | idle fully faded, level 0
// FADING_IN  | level steps up every FRAMES_PER_STEP frame ticks
module screen_fader #(
  parameter int          FRAMES_PER_STEP = 4,
  parameter logic [11:0] TINT_RGB        = 12'h000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic [11:0] rgb_in,
  input  logic        fade_out_req,
  input  logic        fade_in_req,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic [11:0] rgb_out,
  output logic [4:0]  level,
  output logic        busy,
  output logic        fade_done
);

  typedef enum logic [1:0] {
    BRIGHT     = 2'd0,
    FADING_OUT = 2'd1,
    DARK       = 2'd2,
    FADING_IN  = 2'd3
  } state_t;

  state_t      state_q;
  logic [4:0]  level_q;
  logic [7:0]  cnt_q;
  logic        fade_done_q;

  // Stage-1 sync registers double as the registered vsync used for edge detect.
  logic        vsync_s1_q, hsync_s1_q;
  logic        vsync_s2_q, hsync_s2_q;
  logic [8:0]  prod_d [3];
  logic [8:0]  prod_q [3];
  logic [11:0] rgb_q;

  logic tick;
  logic out_req;
  logic in_req;
  logic step;

  assign tick    = vsync_in & ~vsync_s1_q;
  // Conflicting simultaneous requests cancel each other.
  assign out_req = fade_out_req & ~fade_in_req;
  assign in_req  = fade_in_req & ~fade_out_req;
  assign step    = (cnt_q == 8'(FRAMES_PER_STEP - 1));

  // Fade sequencer: an accepted request wins over a frame tick in the same cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= BRIGHT;
      level_q     <= 5'd16;
      cnt_q       <= 8'd0;
      fade_done_q <= 1'b0;
    end else begin
      fade_done_q <= 1'b0;
      case (state_q)
        BRIGHT: begin
          if (out_req) begin
            state_q <= FADING_OUT;
            cnt_q   <= 8'd0;
          end
        end
        FADING_OUT: begin
          if (in_req) begin
            state_q <= FADING_IN;
            cnt_q   <= 8'd0;
          end else if (tick) begin
            if (step) begin
              cnt_q <= 8'd0;
              if (level_q <= 5'd1) begin
                level_q     <= 5'd0;
                state_q     <= DARK;
                fade_done_q <= 1'b1;
              end else begin
                level_q <= level_q - 5'd1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        DARK: begin
          if (in_req) begin
            state_q <= FADING_IN;
            cnt_q   <= 8'd0;
          end
        end
        FADING_IN: begin
          if (out_req) begin
            state_q <= FADING_OUT;
            cnt_q   <= 8'd0;
          end else if (tick) begin
            if (step) begin
              cnt_q <= 8'd0;
              // A reversal can start at level 16, so saturate rather than compare for 15.
              if (level_q >= 5'd15) begin
                level_q     <= 5'd16;
                state_q     <= BRIGHT;
                fade_done_q <= 1'b1;
              end else begin
                level_q <= level_q + 5'd1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= BRIGHT;
      endcase
    end
  end

  // Per-channel weighted products for pipeline stage 1 (max 240, fits 9 bits).
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
`ifdef FADE_TINT_EN
      prod_d[ch] = 9'(rgb_in[ch*4 +: 4]) * 9'(level_q)
                 + 9'(TINT_RGB[ch*4 +: 4]) * 9'(5'd16 - level_q);
`else
      prod_d[ch] = 9'(rgb_in[ch*4 +: 4]) * 9'(level_q);
`endif
    end
  end

  // Two-stage colour/sync pipeline: products, then shifted result.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_s1_q <= 1'b0;
      hsync_s1_q <= 1'b0;
      vsync_s2_q <= 1'b0;
      hsync_s2_q <= 1'b0;
      rgb_q      <= 12'd0;
      for (int ch = 0; ch < 3; ch++) prod_q[ch] <= 9'd0;
    end else begin
      vsync_s1_q <= vsync_in;
      hsync_s1_q <= hsync_in;
      vsync_s2_q <= vsync_s1_q;
      hsync_s2_q <= hsync_s1_q;
      for (int ch = 0; ch < 3; ch++) begin
        prod_q[ch]         <= prod_d[ch];
        rgb_q[ch*4 +: 4]   <= 4'(prod_q[ch] >> 4);
      end
    end
  end

  assign vsync_out = vsync_s2_q;
  assign hsync_out = hsync_s2_q;
  assign rgb_out   = rgb_q;
  assign level     = level_q;
  assign busy      = (state_q == FADING_OUT) || (state_q == FADING_IN);
  assign fade_done = fade_done_q;

endmodule

// File: tb/tb_screen_fader.sv
// Bench for screen_fader: two instances (1 and 4 frames per step) share the
// stimulus; a per-instance reference model predicts pixels and fade state.
module tb_screen_fader;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync_in, hsync_in, fade_out_req, fade_in_req;
  logic [11:0] rgb_in;

  logic        vs_a, hs_a, busy_a, done_a;
  logic [11:0] rgb_a;
  logic [4:0]  lvl_a;
  logic        vs_b, hs_b, busy_b, done_b;
  logic [11:0] rgb_b;
  logic [4:0]  lvl_b;

  always #5 pclk = ~pclk;

  screen_fader #(.FRAMES_PER_STEP(1)) u_a (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .rgb_in(rgb_in), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
    .vsync_out(vs_a), .hsync_out(hs_a), .rgb_out(rgb_a), .level(lvl_a),
    .busy(busy_a), .fade_done(done_a));

  screen_fader #(.FRAMES_PER_STEP(4)) u_b (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .rgb_in(rgb_in), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
    .vsync_out(vs_b), .hsync_out(hs_b), .rgb_out(rgb_b), .level(lvl_b),
    .busy(busy_b), .fade_done(done_b));

  typedef struct packed {logic vs; logic hs; logic [11:0] rgb;} pix_t;
  typedef struct packed {logic [4:0] lvl; logic busy; logic done;} st_t;

  pix_t pq_a[$], pq_b[$];
  st_t  sq_a[$], sq_b[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  // Reference model: level, fade direction (-1 out, 0 idle, +1 in), frame count.
  int m_lvl[2], m_dir[2], m_cnt[2];
  int m_fps[2] = '{1, 4};
  bit m_vsp;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] scale(logic [11:0] c, int l);
    logic [11:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) r[ch*4 +: 4] = 4'((int'(c[ch*4 +: 4]) * l) / 16);
    return r;
  endfunction

  task automatic model_reset();
    pq_a.delete(); pq_b.delete(); sq_a.delete(); sq_b.delete();
    m_vsp = 0;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 16; m_dir[i] = 0; m_cnt[i] = 0;
    end
    // Pipeline and state registers hold reset values for the first outputs seen.
    repeat (2) begin
      pq_a.push_back('0); pq_b.push_back('0);
    end
    sq_a.push_back(st_t'{5'd16, 1'b0, 1'b0});
    sq_b.push_back(st_t'{5'd16, 1'b0, 1'b0});
  endtask

  task automatic model_step(bit vs, bit hs, bit fo, bit fi, logic [11:0] rgb);
    bit tick, want_out, want_in, done;
    pix_t p;
    st_t  s;
    tick     = vs && !m_vsp;
    m_vsp    = vs;
    want_out = fo && !fi;
    want_in  = fi && !fo;
    for (int i = 0; i < 2; i++) begin
      p = '{vs, hs, scale(rgb, m_lvl[i])};
      if (i == 0) pq_a.push_back(p); else pq_b.push_back(p);
      done = 0;
      if (want_out && m_dir[i] != -1 && !(m_dir[i] == 0 && m_lvl[i] == 0)) begin
        m_dir[i] = -1; m_cnt[i] = 0;
      end else if (want_in && m_dir[i] != 1 && !(m_dir[i] == 0 && m_lvl[i] == 16)) begin
        m_dir[i] = 1; m_cnt[i] = 0;
      end else if (tick && m_dir[i] != 0) begin
        m_cnt[i]++;
        if (m_cnt[i] == m_fps[i]) begin
          m_cnt[i] = 0;
          m_lvl[i] += m_dir[i];
          if (m_lvl[i] <= 0 || m_lvl[i] >= 16) begin
            m_lvl[i] = (m_lvl[i] <= 0) ? 0 : 16;
            m_dir[i] = 0;
            done     = 1;
          end
        end
      end
      s = '{5'(m_lvl[i]), m_dir[i] != 0, done};
      if (i == 0) sq_a.push_back(s); else sq_b.push_back(s);
    end
  endtask

  // Monitor: pops expected records and compares, independent of the driver.
  always @(negedge pclk) begin
    pix_t p;
    st_t  s;
    if (mon_en) begin
      if (pq_a.size() >= 3) begin
        p = pq_a.pop_front();
        check("pix_a", int'({vs_a, hs_a, rgb_a}), int'(p));
      end
      if (pq_b.size() >= 3) begin
        p = pq_b.pop_front();
        check("pix_b", int'({vs_b, hs_b, rgb_b}), int'(p));
      end
      if (sq_a.size() >= 2) begin
        s = sq_a.pop_front();
        check("state_a", int'({lvl_a, busy_a, done_a}), int'(s));
      end
      if (sq_b.size() >= 2) begin
        s = sq_b.pop_front();
        check("state_b", int'({lvl_b, busy_b, done_b}), int'(s));
      end
    end
  end

  task automatic cyc(bit vs, bit hs, bit fo, bit fi, logic [11:0] rgb);
    @(posedge pclk);
    #1;
    rst          = 1'b0;
    vsync_in     = vs;
    hsync_in     = hs;
    fade_out_req = fo;
    fade_in_req  = fi;
    rgb_in       = rgb;
    model_step(vs, hs, fo, fi, rgb);
    mon_en       = 1'b1;
  endtask

  // Assert reset with random inputs; outputs must clear immediately.
  task automatic do_reset();
    @(posedge pclk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vsync_in     = 1'($urandom);
      hsync_in     = 1'($urandom);
      fade_out_req = 1'($urandom);
      fade_in_req  = 1'($urandom);
      rgb_in       = 12'($urandom);
      #1;
      check("rst_out_a", int'({vs_a, hs_a, rgb_a, lvl_a, busy_a, done_a}), int'({14'd0, 5'd16, 2'b00}));
      check("rst_out_b", int'({vs_b, hs_b, rgb_b, lvl_b, busy_b, done_b}), int'({14'd0, 5'd16, 2'b00}));
      @(posedge pclk);
      #1;
    end
    model_reset();
  endtask

  task automatic frame(int len, int req_pos, bit fo, bit fi);
    for (int i = 0; i < len; i++)
      cyc(i < 2, (i % 3) == 0, fo && i == req_pos, fi && i == req_pos,
          ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom));
  endtask

  task automatic frames(int n);
    repeat (n) frame(8, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; vsync_in = 0; hsync_in = 0; fade_out_req = 0; fade_in_req = 0; rgb_in = '0;
    do_reset();

    cyc(0, 1, 0, 0, 12'hABC);
    cyc(0, 0, 0, 0, 12'h123);
    repeat (3) cyc(0, 0, 0, 0, 12'h000);
    frames(2);

    // Fade out, then 8 frame ticks.
    frame(8, 3, 1, 0);
    frames(8);
    @(negedge pclk);
    check("lvl_a_after8", lvl_a, 8);
    check("lvl_b_after8", lvl_b, 14);
    for (int i = 0; i < 4; i++) cyc(0, i[0], 0, 0, 12'hFFF);
    @(negedge pclk);
    check("rgb_a_lvl8", rgb_a, 12'h777);
    frames(8);
    @(negedge pclk);
    check("lvl_a_dark", lvl_a, 0);
    check("busy_a_dark", busy_a, 0);

    // Fade in from dark (a) and reversal mid-fade (b).
    frame(8, 5, 0, 1);
    frames(70);
    @(negedge pclk);
    check("lvl_b_bright", lvl_b, 16);
    check("busy_b_bright", busy_b, 0);

    // Simultaneous and redundant requests in BRIGHT.
    frame(8, 4, 1, 1);
    frame(8, 4, 0, 1);
    @(negedge pclk);
    check("lvl_a_both", lvl_a, 16);
    check("busy_a_both", busy_a, 0);

    // Requests at random positions, including on the tick cycle.
    for (int f = 0; f < 80; f++) begin
      int r;
      r = $urandom_range(0, 5);
      frame($urandom_range(4, 12), $urandom_range(0, 3), r == 0 || r == 2, r == 1 || r == 2);
    end

    // Reset mid-fade.
    do_reset();
    frame(8, 3, 1, 0);
    frames(11);
    @(negedge pclk);
    check("lvl_a_mid", lvl_a, 5);
    do_reset();
    frames(3);

    repeat (3) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_fader.md
Name: screen_fader

Overview:
- Post-processing stage directly downstream of the text overlay stage, just before the VGA output registers.
- Takes the final hsync/vsync/rgb stream and scales the colour by a brightness level.
- Brightness steps once per frame in response to fade-out/fade-in requests from game control, giving level transitions and game-over fades.
- Sync signals pass through delay-matched to the colour pipeline.

Parameters:
- FRAMES_PER_STEP, 4: vsync rising edges per brightness step (1..255).
- TINT_RGB, 12'h000: fade target colour; used only when FADE_TINT_EN is defined.

Ports:
- pclk  input  1  pixel clock
- rst  input  1  asynchronous active-high reset
- vsync_in  input  1  vertical sync from text overlay stage
- hsync_in  input  1  horizontal sync from text overlay stage
- rgb_in  input  12  pixel colour {R[11:8],G[7:4],B[3:0]}
- fade_out_req  input  1  single-cycle request to fade to dark
- fade_in_req  input  1  single-cycle request to fade to bright
- vsync_out  output  1  vsync delayed 2 cycles
- hsync_out  output  1  hsync delayed 2 cycles
- rgb_out  output  12  scaled colour, aligned with syncs
- level  output  5  current brightness, 0..16
- busy  output  1  high in FADING_OUT or FADING_IN
- fade_done  output  1  one-cycle pulse on reaching DARK or BRIGHT

Behaviour:
- Reset (async, rst=1): state BRIGHT, level=16, frame counter=0, sync/rgb pipeline registers=0, vsync_out=0, hsync_out=0, rgb_out=0, busy=0, fade_done=0.
- Frame tick: a rising edge of vsync_in, detected against a registered copy of vsync_in. The registered copy resets to 0.
- Pipeline latency is exactly 2 pclk for rgb, hsync and vsync:
  - Stage 1 registers the per-channel products.
  - Stage 2 registers the shifted sum.
- Per channel c (4 bit): out = (c*level) >> 4, with 9-bit intermediate.
  - level 16 gives out = c; level 0 gives 0.
- Level changes only on a frame tick, so brightness never changes mid-frame.
- FSM states:
  - BRIGHT: level=16. fade_out_req -> FADING_OUT, frame counter cleared.
  - FADING_OUT: on each tick the counter increments. When counter reaches FRAMES_PER_STEP-1, it clears and level decrements.
    - Transition from level 1 to 0 -> DARK, fade_done pulses.
    - fade_in_req -> FADING_IN from the current level; counter cleared.
  - DARK: level=0. fade_in_req -> FADING_IN, counter cleared.
  - FADING_IN: mirror of FADING_OUT with level incrementing.
    - Transition from level 15 to 16 -> BRIGHT, fade_done pulses.
    - fade_out_req -> FADING_OUT.
- Redundant requests are ignored: fade_out_req in FADING_OUT/DARK, fade_in_req in FADING_IN/BRIGHT.
- fade_out_req and fade_in_req high in the same cycle: both ignored, state unchanged.
- A request arriving on the same cycle as a tick takes priority: the tick is not applied in that cycle.
- level saturates at 0 and 16; no wrap.
- busy is a combinational decode of state. fade_done is registered, high for exactly one pclk.
- Reset mid-fade returns immediately to BRIGHT/level 16; any in-flight pipeline data is discarded.

Optional Feature:
- Macro FADE_TINT_EN.
- Defined: out = (c*level + t*(16-level)) >> 4, where t is the matching channel of TINT_RGB. Level 0 gives exactly TINT_RGB; level 16 gives exactly rgb_in. Latency remains 2 cycles.
- Undefined: black fade as specified above; TINT_RGB unused; no tint logic synthesised.

Test Plan:
- Reset check: assert rst with random inputs -> rgb_out=0, syncs=0, level=16, busy=0, fade_done=0. Release rst, drive rgb_in=12'hABC -> rgb_out=12'hABC exactly 2 cycles later; syncs delayed by 2.
- Full fade out: FRAMES_PER_STEP=1, pulse fade_out_req, drive 16 vsync rising edges.
  - After the 8th edge: level=8, rgb_in=12'hFFF gives rgb_out=12'h777.
  - After the 16th edge: level=0, rgb_out=12'h000, single fade_done pulse, busy=0.
- Step pacing: FRAMES_PER_STEP=4, fade_out_req, 8 vsync edges -> level=14. Level must be constant between edges, including across hsync activity.
- Reversal: fade out to level 10, pulse fade_in_req -> busy stays 1, level rises 11..16, fade_done pulses once at 16.
- Simultaneous/redundant requests: both requests high in one cycle in BRIGHT -> state BRIGHT, level 16. fade_in_req in BRIGHT -> no change, no fade_done.
- Reset mid-fade at level 5 -> level=16 and busy=0 immediately. With FADE_TINT_EN and TINT_RGB=12'h00F at level 0, rgb_in=12'hF00 -> rgb_out=12'h00F.
